// File: rtl/generation_timer.sv
// Down-counting interval timer pacing generation updates; issues one tick per
// period of frame enables over a valid/ready handshake and flags lost ticks.
module generation_timer #(
   parameter int unsigned width          = 8,
   parameter int unsigned default_period = 60
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             run,
   input  logic             step,
   input  logic             period_wr,
   input  logic [width-1:0] period_in,
   input  logic             tick_ready,
   output logic             tick_valid,
   output logic [width-1:0] count,
   output logic             overrun,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      PEND = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [width-1:0] period_q, period_d, count_d;
   logic [width-1:0] clamped, reload_val;
   logic             tick_d, overrun_d;
   logic             active, terminal, transfer;

   assign clamped    = (period_in == '0) ? width'(1) : period_in;
   // A period write coincident with a terminal event reloads from the new value.
   assign reload_val = (period_wr ? clamped : period_q) - width'(1);
   assign active     = enable & run & (state_q != IDLE);
   assign terminal   = active & (count == '0);
   assign transfer   = tick_valid & tick_ready;
   assign state      = state_q;

   // Next-state, count and flag logic
   always_comb begin
      state_d   = state_q;
      count_d   = count;
      period_d  = period_q;
      tick_d    = tick_valid;
      overrun_d = overrun;

      if (period_wr) begin
         period_d  = clamped;
         overrun_d = 1'b0;
         if (state_q == IDLE) count_d = clamped - width'(1);
      end

      if (terminal)    count_d = reload_val;
      else if (active) count_d = count - width'(1);

      case (state_q)
         IDLE: begin
            if (run) begin
               state_d = RUN;
            end else if (step) begin
               tick_d  = 1'b1;
               state_d = PEND;
            end
         end
         RUN: begin
            if (!run) begin
               state_d = IDLE;
            end else if (terminal) begin
               tick_d  = 1'b1;
               state_d = PEND;
            end
         end
         PEND: begin
            // A tick lost to backpressure wins over a same-cycle period write.
            if (transfer && !terminal) begin
               tick_d  = 1'b0;
               state_d = run ? RUN : IDLE;
            end else if (!transfer && terminal) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tick_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         period_q   <= width'(default_period);
         count      <= width'(default_period - 1);
         tick_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         count      <= count_d;
         tick_valid <= tick_d;
         overrun    <= overrun_d;
      end
   end

endmodule

// File: tb/tb_generation_timer.sv
// Bench for generation_timer: directed scenarios then random traffic, all
// outputs compared every cycle against a behavioural model of the timer.
module tb_generation_timer;

   localparam int unsigned W  = 8;
   localparam int unsigned DP = 60;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         enable = 1'b0, run = 1'b0, step = 1'b0, period_wr = 1'b0;
   logic [W-1:0] period_in = '0;
   logic         tick_ready = 1'b0;
   logic         tick_valid, overrun;
   logic [W-1:0] count;
   logic [1:0]   state;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: 0 idle, 1 running, 2 tick pending
   int m_state, m_count, m_period, m_valid, m_over;

   generation_timer #(.width(W), .default_period(DP)) dut (
      .clk(clk), .reset(reset), .enable(enable), .run(run), .step(step),
      .period_wr(period_wr), .period_in(period_in), .tick_ready(tick_ready),
      .tick_valid(tick_valid), .count(count), .overrun(overrun), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
   endtask

   // Apply the timer's rules to the inputs present before the coming edge.
   task automatic model_step();
      int  clampv, nxt_count, nxt_state, nxt_valid, nxt_over;
      bit  active, term, xfer;
      if (reset) begin
         m_state = 0; m_period = DP; m_count = DP - 1; m_valid = 0; m_over = 0;
         return;
      end
      clampv    = (period_in == 0) ? 1 : int'(period_in);
      active    = enable && run && (m_state != 0);
      term      = active && (m_count == 0);
      xfer      = (m_valid == 1) && tick_ready;
      nxt_state = m_state;
      nxt_valid = m_valid;
      nxt_over  = period_wr ? 0 : m_over;
      if (term)                        nxt_count = (period_wr ? clampv : m_period) - 1;
      else if (active)                 nxt_count = m_count - 1;
      else if (period_wr && m_state == 0) nxt_count = clampv - 1;
      else                             nxt_count = m_count;
      if (m_state == 0) begin
         if (run) nxt_state = 1;
         else if (step) begin nxt_state = 2; nxt_valid = 1; end
      end else if (m_state == 1) begin
         if (!run) nxt_state = 0;
         else if (term) begin nxt_state = 2; nxt_valid = 1; end
      end else begin
         if (xfer && !term) begin nxt_valid = 0; nxt_state = run ? 1 : 0; end
         else if (!xfer && term) nxt_over = 1;
      end
      if (period_wr) m_period = clampv;
      m_state = nxt_state; m_count = nxt_count; m_valid = nxt_valid; m_over = nxt_over;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("state", 32'(state), 32'(m_state));
      chk("count", 32'(count), 32'(m_count));
      chk("tick_valid", 32'(tick_valid), 32'(m_valid));
      chk("overrun", 32'(overrun), 32'(m_over));
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int saved;
      int ticks;

      // Reset state
      cycles(2);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_count", 32'(count), 32'(DP - 1));
      chk("reset_valid", 32'(tick_valid), 32'd0);
      chk("reset_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;

      // Period 4 free-run: one tick per 4 enables
      period_wr = 1'b1; period_in = 8'd4;
      cycle();
      chk("p4_load_count", 32'(count), 32'd3);
      period_wr = 1'b0; run = 1'b1; enable = 1'b1; tick_ready = 1'b1;
      cycle();
      chk("p4_run_no_dec", 32'(count), 32'd3);
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         chk("p4_count_seq", 32'(count), 32'((3 - ((i + 1) % 4) + 4) % 4));
         if (tick_valid) ticks++;
      end
      chk("p4_tick_count", 32'(ticks), 32'd3);

      // Single step with backpressure
      run = 1'b0; enable = 1'b0;
      cycles(3);
      saved = int'(count);
      step = 1'b1; tick_ready = 1'b0;
      cycle();
      step = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("step_held", 32'(tick_valid), 32'd1);
      end
      tick_ready = 1'b1;
      cycle();
      tick_ready = 1'b0;
      cycle();
      chk("step_done_valid", 32'(tick_valid), 32'd0);
      chk("step_done_state", 32'(state), 32'd0);
      chk("step_count_kept", 32'(count), 32'(saved));

      // Period 2 with no ready: overrun, single pending tick, cleared by write
      period_wr = 1'b1; period_in = 8'd2;
      cycle();
      period_wr = 1'b0; run = 1'b1; enable = 1'b1;
      cycles(8);
      chk("ovr_set", 32'(overrun), 32'd1);
      chk("ovr_valid", 32'(tick_valid), 32'd1);
      enable = 1'b0; period_wr = 1'b1;
      cycle();
      period_wr = 1'b0;
      chk("ovr_cleared", 32'(overrun), 32'd0);

      // Period 0 clamps to 1: tick every enable, stays pending
      tick_ready = 1'b1; period_wr = 1'b1; period_in = 8'd0;
      cycle();
      period_wr = 1'b0; enable = 1'b1;
      cycles(8);
      chk("p1_valid", 32'(tick_valid), 32'd1);
      chk("p1_state", 32'(state), 32'd2);
      chk("p1_overrun", 32'(overrun), 32'd0);

      // Reset while a tick is pending
      reset = 1'b1;
      cycle();
      reset = 1'b0; run = 1'b0; enable = 1'b0;
      chk("rst_pend_valid", 32'(tick_valid), 32'd0);
      chk("rst_pend_state", 32'(state), 32'd0);
      chk("rst_pend_count", 32'(count), 32'(DP - 1));

      // Pause and resume; step ignored while running
      period_wr = 1'b1; period_in = 8'd8;
      cycle();
      period_wr = 1'b0; run = 1'b1; enable = 1'b1;
      cycles(3);
      chk("pause_at5", 32'(count), 32'd5);
      run = 1'b0;
      cycles(3);
      chk("pause_hold", 32'(count), 32'd5);
      run = 1'b1;
      cycle();
      step = 1'b1;
      cycle();
      step = 1'b0;
      chk("run_step_ign", 32'(tick_valid), 32'd0);
      cycle();
      chk("resume_count", 32'(count), 32'd3);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         reset      = ($urandom_range(0, 63) == 0);
         enable     = ($urandom_range(0, 3) != 0);
         run        = ($urandom_range(0, 7) != 0);
         step       = ($urandom_range(0, 7) == 0);
         tick_ready = $urandom_range(0, 1) == 1;
         period_wr  = ($urandom_range(0, 15) == 0);
         period_in  = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 5));
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
